fma16_issue: RTL

Operand-issue and result-capture stage wrapped around the combinational `fma16` datapath. It accepts FMA commands over a valid/ready interface and buffers them in a small FIFO. It decodes each opcode into the `mul`/`add`/`negr`/`negz` controls, registers the operands that drive `fma16`, and captures `fma_result` into an output register with its own valid/ready handshake. This gives the combinational core a clocked, back-pressurable pipeline with throughput of one operation per cycle.

---
 rtl/fma16_issue_if.sv | 27 ++
 rtl/fma16_issue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fma16_issue_if.sv
// Command and result channels of the fma16 issue stage.
// The master side offers commands and consumes results; the slave side is the issue stage.
interface fma16_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] in_z;
  logic [1:0]  in_rm;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_tag;
  logic        out_err;

  modport master (
    output in_valid, in_op, in_x, in_y, in_z, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_op, in_x, in_y, in_z, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_err
  );
endinterface

// File: rtl/fma16_issue.sv
// Issue stage around the combinational fma16 core.
// The path is command FIFO -> S1 operand register (drives fma_*) -> S2 result register.
module fma16_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  fma16_issue_if.slave bus,
  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  output logic        fma_mul,
  output logic        fma_add,
  output logic        fma_negr,
  output logic        fma_negz,
  output logic [1:0]  fma_rm,
  input  logic [15:0] fma_result,
  output logic        busy,
  output logic [15:0] done_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [1:0]  rm;
    logic [3:0]  tag;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, s2_adv;
  logic          s1_valid, s1_err;
  logic [3:0]    s1_tag;
  logic [3:0]    ctl;

  assign head         = mem[rd_ptr];
  // Full is judged on the registered count alone, so a pop never frees a slot in the same cycle.
  assign bus.in_ready = (count < FULL);
  assign push         = bus.in_valid & bus.in_ready;
  assign s2_adv       = s1_valid & (~bus.out_valid | bus.out_ready);
  assign pop          = (count != '0) & (~s1_valid | s2_adv);
  assign busy         = (count != '0) | s1_valid | bus.out_valid;

  // {mul, add, negr, negz}
  always_comb begin
    ctl = 4'b0000;
    case (head.op)
      3'd0: ctl = 4'b0100;
      3'd1: ctl = 4'b0101;
      3'd2: ctl = 4'b1000;
      3'd3: ctl = 4'b1100;
      3'd4: ctl = 4'b1101;
      3'd5: ctl = 4'b1110;
      3'd6: ctl = 4'b1111;
      default: ctl = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{op: bus.in_op, x: bus.in_x, y: bus.in_y, z: bus.in_z,
                       rm: bus.in_rm, tag: bus.in_tag};
  end

  // Controls are decoded on load so a reset S1 presents all-zero controls to the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_tag   <= '0;
      fma_x    <= '0;
      fma_y    <= '0;
      fma_z    <= '0;
      fma_rm   <= '0;
      {fma_mul, fma_add, fma_negr, fma_negz} <= 4'b0000;
    end else if (pop) begin
      s1_valid <= 1'b1;
      s1_err   <= (head.op == 3'b111);
      s1_tag   <= head.tag;
      fma_x    <= head.x;
      fma_y    <= head.y;
      fma_z    <= head.z;
      fma_rm   <= head.rm;
      {fma_mul, fma_add, fma_negr, fma_negz} <= ctl;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
      bus.out_err    <= 1'b0;
      done_count     <= '0;
    end else begin
      if (s2_adv) begin
        bus.out_valid  <= 1'b1;
        bus.out_result <= s1_err ? 16'h7E00 : fma_result;
        bus.out_tag    <= s1_tag;
        bus.out_err    <= s1_err;
      end else if (bus.out_ready) begin
        bus.out_valid  <= 1'b0;
      end
      if (bus.out_valid & bus.out_ready) done_count <= done_count + 16'd1;
    end
  end
endmodule
